// File: rtl/rv32_core.sv
// Minimal two-stage in-order RV32I core: an IF/ID latch followed by a single
// execute/writeback stage, with registered data-memory requests.
module rv32_core #(
    parameter logic [31:0] MEM_CACHE_ADDR_MIN = 32'h80000000,
    parameter logic [31:0] MEM_CACHE_ADDR_MAX = 32'h8fffffff
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_i_rd_o,
    output logic [31:0] mem_i_pc_o,
    input  logic        mem_i_accept_i,
    input  logic        mem_i_valid_i,
    input  logic [31:0] mem_i_inst_i,
    input  logic        mem_i_error_i,
    output logic        mem_i_flush_o,
    output logic        mem_i_invalidate_o,
    output logic [31:0] mem_d_addr_o,
    output logic [31:0] mem_d_data_wr_o,
    output logic        mem_d_rd_o,
    output logic [3:0]  mem_d_wr_o,
    output logic        mem_d_cacheable_o,
    output logic [10:0] mem_d_req_tag_o,
    output logic        mem_d_invalidate_o,
    output logic        mem_d_writeback_o,
    output logic        mem_d_flush_o,
    input  logic        mem_d_accept_i,
    input  logic        mem_d_ack_i,
    input  logic [31:0] mem_d_data_rd_i,
    input  logic        mem_d_error_i,
    input  logic [10:0] mem_d_resp_tag_i,
    input  logic        intr_i,
    input  logic [31:0] reset_vector_i,
    input  logic [31:0] cpu_id_i
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [31:0] INST_NOP = 32'h00000013;

    typedef enum logic {ST_RESET, ST_RUN} state_t;
    state_t state_q, state_d;

    logic [31:0] pc_q, ifid_inst_q, ifid_pc_q;
    logic        ifid_valid_q;
    logic [31:0] regs_q [32];
    logic [31:0] d_addr_q, d_data_q;
    logic [3:0]  d_wr_q;
    logic        d_rd_q, d_cache_q;
    logic        ld_busy_q;
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_off_q;

    logic        stall, fetch_en, fetch_fire, exec_en;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_res, ea, wb_data, target, st_data, ld_shift, ld_data;
    logic [3:0]  st_be;
    logic        op_is_reg, br_taken, wb_en, take, st_en, ld_en, ea_cache;
    logic        unused_ok;

    // A stored request stalls only while unaccepted; a load stalls through its ack cycle.
    assign stall      = ((d_wr_q != 4'h0) && !mem_d_accept_i) || ld_busy_q;
    assign fetch_en   = (state_q == ST_RUN) && !stall;
    assign fetch_fire = fetch_en && mem_i_valid_i;
    assign exec_en    = ifid_valid_q && !stall;

    assign opcode = ifid_inst_q[6:0];
    assign rd     = ifid_inst_q[11:7];
    assign f3     = ifid_inst_q[14:12];
    assign rs1    = ifid_inst_q[19:15];
    assign rs2    = ifid_inst_q[24:20];
    assign f7     = ifid_inst_q[31:25];
    assign rs1_v  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_v  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    assign imm_i  = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:20]};
    assign imm_s  = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:25], ifid_inst_q[11:7]};
    assign imm_b  = {{19{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[7],
                     ifid_inst_q[30:25], ifid_inst_q[11:8], 1'b0};
    assign imm_u  = {ifid_inst_q[31:12], 12'b0};
    assign imm_j  = {{11{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[19:12],
                     ifid_inst_q[20], ifid_inst_q[30:21], 1'b0};

    always_comb begin
        op_is_reg = (opcode == OP_OP);
        alu_b     = op_is_reg ? rs2_v : imm_i;
        shamt     = alu_b[4:0];
        ea        = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
        ea_cache  = (ea >= MEM_CACHE_ADDR_MIN) && (ea <= MEM_CACHE_ADDR_MAX);
        case (f3)
            3'b000:  alu_res = (op_is_reg && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001:  alu_res = rs1_v << shamt;
            3'b010:  alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_v < alu_b};
            3'b100:  alu_res = rs1_v ^ alu_b;
            3'b101:  alu_res = f7[5] ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'b110:  alu_res = rs1_v | alu_b;
            default: alu_res = rs1_v & alu_b;
        endcase
        case (f3)
            3'b000:  br_taken = (rs1_v == rs2_v);
            3'b001:  br_taken = (rs1_v != rs2_v);
            3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
            3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110:  br_taken = (rs1_v < rs2_v);
            3'b111:  br_taken = (rs1_v >= rs2_v);
            default: br_taken = 1'b0;
        endcase
        wb_en   = 1'b0;
        wb_data = '0;
        take    = 1'b0;
        target  = '0;
        st_en   = 1'b0;
        ld_en   = 1'b0;
        st_be   = '0;
        st_data = '0;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_data = ifid_pc_q + imm_u; end
            OP_JAL: begin
                wb_en = 1'b1; wb_data = ifid_pc_q + 32'd4;
                take  = 1'b1; target  = ifid_pc_q + imm_j;
            end
            OP_JALR: begin
                wb_en = 1'b1; wb_data = ifid_pc_q + 32'd4;
                take  = 1'b1; target  = {ea[31:1], 1'b0};
            end
            OP_BR: begin take = br_taken; target = ifid_pc_q + imm_b; end
            OP_LOAD: ld_en = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                             (f3 == 3'b100) || (f3 == 3'b101);
            OP_STORE: begin
                case (f3)
                    3'b000: begin st_en = 1'b1; st_be = 4'b0001 << ea[1:0];
                                  st_data = {4{rs2_v[7:0]}}; end
                    3'b001: begin st_en = 1'b1; st_be = 4'b0011 << {ea[1], 1'b0};
                                  st_data = {2{rs2_v[15:0]}}; end
                    3'b010: begin st_en = 1'b1; st_be = 4'hF; st_data = rs2_v; end
                    default: ;
                endcase
            end
            OP_IMM: begin wb_en = 1'b1; wb_data = alu_res; end
            OP_OP: begin
                wb_en   = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                wb_data = alu_res;
            end
            default: ;
        endcase
    end

    assign ld_shift = mem_d_data_rd_i >> {ld_off_q, 3'b000};
    always_comb begin
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'b0, ld_shift[7:0]};
            3'b101:  ld_data = {16'b0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RESET) state_d = ST_RUN;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= '0;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= INST_NOP;
            ifid_pc_q    <= '0;
        end else begin
            if (state_q == ST_RESET)  pc_q <= reset_vector_i;
            else if (exec_en && take) pc_q <= target;
            else if (fetch_fire)      pc_q <= pc_q + 32'd4;
            if (fetch_fire && !(exec_en && take)) begin
                ifid_valid_q <= 1'b1;
                ifid_inst_q  <= mem_i_error_i ? INST_NOP : mem_i_inst_i;
                ifid_pc_q    <= pc_q;
            end else if (exec_en) begin
                ifid_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            if (exec_en && wb_en && (rd != 5'd0)) regs_q[rd] <= wb_data;
            if (ld_busy_q && mem_d_ack_i && (ld_rd_q != 5'd0))
                regs_q[ld_rd_q] <= mem_d_error_i ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            d_addr_q  <= '0;
            d_data_q  <= '0;
            d_wr_q    <= '0;
            d_rd_q    <= 1'b0;
            d_cache_q <= 1'b0;
            ld_busy_q <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
        end else begin
            if (exec_en && st_en) begin
                d_addr_q  <= {ea[31:2], 2'b00};
                d_data_q  <= st_data;
                d_wr_q    <= st_be;
                d_rd_q    <= 1'b0;
                d_cache_q <= ea_cache;
            end else if (exec_en && ld_en) begin
                d_addr_q  <= {ea[31:2], 2'b00};
                d_rd_q    <= 1'b1;
                d_cache_q <= ea_cache;
                ld_busy_q <= 1'b1;
                ld_rd_q   <= rd;
                ld_f3_q   <= f3;
                ld_off_q  <= ea[1:0];
            end else begin
                if (mem_d_accept_i) begin
                    d_wr_q <= '0;
                    d_rd_q <= 1'b0;
                end
                if (ld_busy_q && mem_d_ack_i) ld_busy_q <= 1'b0;
            end
        end
    end

    assign mem_i_rd_o         = fetch_en;
    assign mem_i_pc_o         = pc_q;
    assign mem_i_flush_o      = 1'b0;
    assign mem_i_invalidate_o = 1'b0;
    assign mem_d_addr_o       = d_addr_q;
    assign mem_d_data_wr_o    = d_data_q;
    assign mem_d_rd_o         = d_rd_q;
    assign mem_d_wr_o         = d_wr_q;
    assign mem_d_cacheable_o  = d_cache_q;
    assign mem_d_req_tag_o    = '0;
    assign mem_d_invalidate_o = 1'b0;
    assign mem_d_writeback_o  = 1'b0;
    assign mem_d_flush_o      = 1'b0;
    assign unused_ok = ^{mem_i_accept_i, mem_d_resp_tag_i, intr_i, cpu_id_i};
endmodule

// File: tb/tb_rv32_core.sv
// Directed bench for rv32_core: small instruction ROM, store logger and
// per-scenario tasks with hand-computed expectations.
module tb_rv32_core;
    localparam logic [31:0] BASE = 32'h80000000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_o, mem_i_accept_i, mem_i_valid_i, mem_i_error_i;
    logic        mem_i_flush_o, mem_i_invalidate_o;
    logic [31:0] mem_i_pc_o, mem_i_inst_i;
    logic [31:0] mem_d_addr_o, mem_d_data_wr_o, mem_d_data_rd_i;
    logic        mem_d_rd_o, mem_d_cacheable_o;
    logic [3:0]  mem_d_wr_o;
    logic [10:0] mem_d_req_tag_o, mem_d_resp_tag_i;
    logic        mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o;
    logic        mem_d_accept_i, mem_d_ack_i, mem_d_error_i, intr_i;
    logic [31:0] reset_vector_i, cpu_id_i;

    logic [31:0] imem [16];
    logic [31:0] imem_off;
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_be [$];
    logic        wq_cache [$];
    int unsigned total = 0;
    int unsigned bad = 0;

    rv32_core #(.MEM_CACHE_ADDR_MIN(32'h80000000), .MEM_CACHE_ADDR_MAX(32'h8fffffff)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_i_rd_o(mem_i_rd_o), .mem_i_pc_o(mem_i_pc_o), .mem_i_accept_i(mem_i_accept_i),
        .mem_i_valid_i(mem_i_valid_i), .mem_i_inst_i(mem_i_inst_i), .mem_i_error_i(mem_i_error_i),
        .mem_i_flush_o(mem_i_flush_o), .mem_i_invalidate_o(mem_i_invalidate_o),
        .mem_d_addr_o(mem_d_addr_o), .mem_d_data_wr_o(mem_d_data_wr_o), .mem_d_rd_o(mem_d_rd_o),
        .mem_d_wr_o(mem_d_wr_o), .mem_d_cacheable_o(mem_d_cacheable_o),
        .mem_d_req_tag_o(mem_d_req_tag_o), .mem_d_invalidate_o(mem_d_invalidate_o),
        .mem_d_writeback_o(mem_d_writeback_o), .mem_d_flush_o(mem_d_flush_o),
        .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
        .mem_d_data_rd_i(mem_d_data_rd_i), .mem_d_error_i(mem_d_error_i),
        .mem_d_resp_tag_i(mem_d_resp_tag_i), .intr_i(intr_i),
        .reset_vector_i(reset_vector_i), .cpu_id_i(cpu_id_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        imem_off     = mem_i_pc_o - BASE;
        mem_i_inst_i = (imem_off < 32'd64) ? imem[imem_off[5:2]] : NOP;
    end

    // Accepted stores are logged mid-cycle, after inputs settle.
    always @(negedge clk_i) begin
        if (rst_i && (mem_d_wr_o != 4'h0) && mem_d_accept_i) begin
            wq_addr.push_back(mem_d_addr_o);
            wq_data.push_back(mem_d_data_wr_o);
            wq_be.push_back(mem_d_wr_o);
            wq_cache.push_back(mem_d_cacheable_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) imem[i] = NOP;
    endtask

    task automatic restart();
        rst_i = 1'b0;
        tick();
        tick();
        wq_addr.delete(); wq_data.delete(); wq_be.delete(); wq_cache.delete();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_prog();
        rst_i = 1'b0;
        tick();
        total += 5;
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL rst_i_rd got=%b exp=0", mem_i_rd_o); end
        if (mem_i_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", mem_i_pc_o); end
        if (mem_d_rd_o !== 1'b0) begin bad++; $display("FAIL rst_d_rd got=%b exp=0", mem_d_rd_o); end
        if (mem_d_wr_o !== 4'h0) begin bad++; $display("FAIL rst_d_wr got=%h exp=0", mem_d_wr_o); end
        if (mem_d_addr_o !== 32'h0) begin bad++; $display("FAIL rst_d_addr got=%h exp=0", mem_d_addr_o); end
        rst_i = 1'b1;
        #1;
        total++;
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL boot_rd1 got=%b exp=0", mem_i_rd_o); end
        tick();
        total += 2;
        if (mem_i_pc_o !== BASE) begin bad++; $display("FAIL boot_pc got=%h exp=%h", mem_i_pc_o, BASE); end
        if (mem_i_rd_o !== 1'b1) begin bad++; $display("FAIL boot_rd2 got=%b exp=1", mem_i_rd_o); end
    endtask

    task automatic test_back_to_back();
        clear_prog();
        imem[0] = 32'h800005B7; imem[1] = 32'h90000637; imem[2] = 32'hDEADB6B7;
        imem[3] = 32'hEEF68693; imem[4] = 32'h00D5A023; imem[5] = NOP;
        imem[6] = 32'h00D62023;
        mem_d_accept_i = 1'b1;
        restart();
        for (int i = 0; i < 25; i++) tick();
        total++;
        if (wq_addr.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", wq_addr.size()); end
        if (wq_addr.size() >= 2) begin
            total += 8;
            if (wq_addr[0] !== 32'h80000000) begin bad++; $display("FAIL b2b_addr0 got=%h exp=80000000", wq_addr[0]); end
            if (wq_data[0] !== 32'hDEADAEEF) begin bad++; $display("FAIL b2b_data0 got=%h exp=deadaeef", wq_data[0]); end
            if (wq_be[0] !== 4'hF) begin bad++; $display("FAIL b2b_be0 got=%h exp=f", wq_be[0]); end
            if (wq_cache[0] !== 1'b1) begin bad++; $display("FAIL b2b_cache0 got=%b exp=1", wq_cache[0]); end
            if (wq_addr[1] !== 32'h90000000) begin bad++; $display("FAIL b2b_addr1 got=%h exp=90000000", wq_addr[1]); end
            if (wq_data[1] !== 32'hDEADAEEF) begin bad++; $display("FAIL b2b_data1 got=%h exp=deadaeef", wq_data[1]); end
            if (wq_be[1] !== 4'hF) begin bad++; $display("FAIL b2b_be1 got=%h exp=f", wq_be[1]); end
            if (wq_cache[1] !== 1'b0) begin bad++; $display("FAIL b2b_cache1 got=%b exp=0", wq_cache[1]); end
        end
    endtask

    task automatic test_store_byte_hold();
        logic        found;
        logic [31:0] pc_hold;
        clear_prog();
        imem[0] = 32'h800005B7; imem[1] = 32'hDEADB6B7; imem[2] = 32'hEEF68693;
        imem[3] = 32'h00D581A3;
        mem_d_accept_i = 1'b0;
        restart();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_d_wr_o != 4'h0) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL sb_timeout got=no store exp=store"); end
        pc_hold = mem_i_pc_o;
        tick();
        total += 5;
        if (mem_d_addr_o !== 32'h80000000) begin bad++; $display("FAIL sb_addr got=%h exp=80000000", mem_d_addr_o); end
        if (mem_d_wr_o !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", mem_d_wr_o); end
        if (mem_d_data_wr_o !== 32'hEFEFEFEF) begin bad++; $display("FAIL sb_data got=%h exp=efefefef", mem_d_data_wr_o); end
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL sb_stall got=%b exp=0", mem_i_rd_o); end
        if (mem_i_pc_o !== pc_hold) begin bad++; $display("FAIL sb_pc_hold got=%h exp=%h", mem_i_pc_o, pc_hold); end
        mem_d_accept_i = 1'b1;
        tick();
        tick();
        total += 3;
        if (mem_d_wr_o !== 4'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", mem_d_wr_o); end
        if (mem_i_rd_o !== 1'b1) begin bad++; $display("FAIL sb_resume got=%b exp=1", mem_i_rd_o); end
        if (wq_addr.size() != 1) begin bad++; $display("FAIL sb_count got=%0d exp=1", wq_addr.size()); end
    endtask

    task automatic test_load_late_ack();
        logic        found;
        logic [31:0] pc_hold;
        clear_prog();
        imem[0] = 32'h800005B7; imem[1] = 32'h00158283; imem[2] = 32'h0055A023;
        mem_d_accept_i = 1'b1;
        restart();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_d_rd_o) found = 1'b1;
            else tick();
        end
        total += 4;
        if (!found) begin bad++; $display("FAIL lb_timeout got=no load exp=load"); end
        if (mem_d_addr_o !== 32'h80000000) begin bad++; $display("FAIL lb_addr got=%h exp=80000000", mem_d_addr_o); end
        if (mem_d_cacheable_o !== 1'b1) begin bad++; $display("FAIL lb_cache got=%b exp=1", mem_d_cacheable_o); end
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL lb_stall0 got=%b exp=0", mem_i_rd_o); end
        pc_hold = mem_i_pc_o;
        tick();
        total += 2;
        if (mem_d_rd_o !== 1'b0) begin bad++; $display("FAIL lb_accepted got=%b exp=0", mem_d_rd_o); end
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL lb_stall1 got=%b exp=0", mem_i_rd_o); end
        tick();
        mem_d_ack_i = 1'b1;
        mem_d_data_rd_i = 32'h00008000;
        #1;
        total++;
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL lb_stall_ack got=%b exp=0", mem_i_rd_o); end
        tick();
        mem_d_ack_i = 1'b0;
        mem_d_data_rd_i = 32'h0;
        #1;
        total += 2;
        if (mem_i_rd_o !== 1'b1) begin bad++; $display("FAIL lb_resume got=%b exp=1", mem_i_rd_o); end
        if (mem_i_pc_o !== pc_hold) begin bad++; $display("FAIL lb_pc_hold got=%h exp=%h", mem_i_pc_o, pc_hold); end
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (wq_data.size() != 1) begin bad++; $display("FAIL lb_count got=%0d exp=1", wq_data.size()); end
        else begin
            total++;
            if (wq_data[0] !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_value got=%h exp=ffffff80", wq_data[0]); end
        end
    endtask

    task automatic test_branch_squash();
        logic found;
        clear_prog();
        imem[0] = 32'h800005B7; imem[1] = 32'h00000463; imem[2] = 32'h00B5A023;
        imem[3] = 32'h00B5A223;
        mem_d_accept_i = 1'b1;
        restart();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_i_pc_o == 32'h80000008) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL br_timeout got=%h exp=80000008", mem_i_pc_o); end
        tick();
        total++;
        if (mem_i_pc_o !== 32'h8000000C) begin bad++; $display("FAIL br_target got=%h exp=8000000c", mem_i_pc_o); end
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (wq_addr.size() != 1) begin bad++; $display("FAIL br_count got=%0d exp=1", wq_addr.size()); end
        else begin
            total += 2;
            if (wq_addr[0] !== 32'h80000004) begin bad++; $display("FAIL br_addr got=%h exp=80000004", wq_addr[0]); end
            if (wq_data[0] !== 32'h80000000) begin bad++; $display("FAIL br_data got=%h exp=80000000", wq_data[0]); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic found;
        clear_prog();
        imem[0] = 32'h800005B7; imem[1] = 32'h00158283; imem[2] = 32'h0055A023;
        mem_d_accept_i = 1'b1;
        restart();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_d_rd_o) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL rml_timeout got=no load exp=load"); end
        rst_i = 1'b0;
        #1;
        total += 4;
        if (mem_d_rd_o !== 1'b0) begin bad++; $display("FAIL rml_d_rd got=%b exp=0", mem_d_rd_o); end
        if (mem_d_wr_o !== 4'h0) begin bad++; $display("FAIL rml_d_wr got=%h exp=0", mem_d_wr_o); end
        if (mem_d_addr_o !== 32'h0) begin bad++; $display("FAIL rml_addr got=%h exp=0", mem_d_addr_o); end
        if (mem_i_rd_o !== 1'b0) begin bad++; $display("FAIL rml_i_rd got=%b exp=0", mem_i_rd_o); end
        mem_d_ack_i = 1'b1;
        mem_d_data_rd_i = 32'h00008000;
        tick();
        wq_data.delete(); wq_addr.delete(); wq_be.delete(); wq_cache.delete();
        rst_i = 1'b1;
        tick();
        mem_d_ack_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_d_rd_o) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL rml_timeout2 got=no load exp=load"); end
        mem_d_ack_i = 1'b1;
        mem_d_data_rd_i = 32'h00001200;
        tick();
        mem_d_ack_i = 1'b0;
        mem_d_data_rd_i = 32'h0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (wq_data.size() != 1) begin bad++; $display("FAIL rml_count got=%0d exp=1", wq_data.size()); end
        else begin
            total++;
            if (wq_data[0] !== 32'h00000012) begin bad++; $display("FAIL rml_value got=%h exp=00000012", wq_data[0]); end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        mem_i_accept_i = 1'b1; mem_i_valid_i = 1'b1; mem_i_error_i = 1'b0;
        mem_d_accept_i = 1'b1; mem_d_ack_i = 1'b0; mem_d_data_rd_i = '0;
        mem_d_error_i = 1'b0; mem_d_resp_tag_i = '0; intr_i = 1'b0;
        reset_vector_i = BASE; cpu_id_i = '0;
        clear_prog();
        test_reset();
        test_back_to_back();
        test_store_byte_hold();
        test_load_late_ack();
        test_branch_squash();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
